// File: rtl/fdiv_pkg.sv
// fdiv_sched shared types and constants.
// Scheduler states and IEEE 754 single-precision classification helpers.
package fdiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CAPT
  } fdiv_state_e;

  localparam logic [7:0]  FP_EXP_ONES = 8'hFF;
  localparam logic [31:0] FP_QNAN     = 32'h7FC00000;

  function automatic logic fp_is_nan(input logic [31:0] x);
    return (x[30:23] == FP_EXP_ONES) && (x[22:0] != '0);
  endfunction

  function automatic logic fp_is_inf(input logic [31:0] x);
    return (x[30:23] == FP_EXP_ONES) && (x[22:0] == '0);
  endfunction

endpackage

// File: rtl/fdiv_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first request at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW:0] j;
  logic        found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      j = {1'b0, ptr} + (IW+1)'(k);
      if (j >= (IW+1)'(N)) j = j - (IW+1)'(N);
      if (en && !found && req[j[IW-1:0]]) begin
        gnt[j[IW-1:0]] = 1'b1;
        idx            = j[IW-1:0];
        found          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fdiv_sched.sv
// Round-robin scheduler sharing one FP divider among N_REQ requesters.
// Operands are held stable until the registered quotient is captured.
module fdiv_sched
  import fdiv_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int W       = 32,
  parameter  int DIV_LAT = 2,
  localparam int ID_W    = $clog2(N_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               enable_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [N_REQ*W-1:0] req_a_i,
  input  logic [N_REQ*W-1:0] req_b_i,
  output logic [N_REQ-1:0]   req_ready_o,
  output logic [W-1:0]       div_a_o,
  output logic [W-1:0]       div_b_o,
  input  logic [W-1:0]       div_result_i,
  output logic               rsp_valid_o,
  output logic [ID_W-1:0]    rsp_id_o,
  output logic [W-1:0]       rsp_result_o,
  output logic               rsp_nan_o,
  output logic               rsp_inf_o,
  output logic               busy_o
);

  localparam int CW = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

  fdiv_state_e     state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] id_q;
  logic [ID_W-1:0] g_idx;
  logic [N_REQ-1:0] gnt;
  logic            grant_en;
  logic            hs;

  // Ready must stay low while reset is held, even though state reads IDLE.
  assign grant_en    = enable_i && rst_ni && (state_q != WAIT);
  assign req_ready_o = gnt;
  assign hs          = |(gnt & req_valid_i);
  assign busy_o      = (state_q != IDLE);

  rr_arbiter #(
    .N  (N_REQ),
    .IW (ID_W)
  ) u_arb (
    .req (req_valid_i),
    .ptr (rr_ptr_q),
    .en  (grant_en),
    .gnt (gnt),
    .idx (g_idx)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (hs) state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = CAPT;
      CAPT:    state_d = hs ? WAIT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_a_o      <= '0;
      div_b_o      <= '0;
      id_q         <= '0;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      rsp_valid_o  <= 1'b0;
      rsp_id_o     <= '0;
      rsp_result_o <= '0;
      rsp_nan_o    <= 1'b0;
      rsp_inf_o    <= 1'b0;
    end else begin
      rsp_valid_o <= (state_q == CAPT);
      if (hs) begin
        div_a_o  <= req_a_i[g_idx*W +: W];
        div_b_o  <= req_b_i[g_idx*W +: W];
        id_q     <= g_idx;
        rr_ptr_q <= (g_idx == ID_W'(N_REQ-1)) ? '0 : g_idx + 1'b1;
        cnt_q    <= CW'(DIV_LAT-1);
      end else if (state_q == WAIT && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (state_q == CAPT) begin
        rsp_result_o <= div_result_i;
        rsp_id_o     <= id_q;
        rsp_nan_o    <= fp_is_nan(div_result_i);
        rsp_inf_o    <= fp_is_inf(div_result_i);
      end
    end
  end

endmodule

// File: tb/tb_fdiv_sched.sv
// Scoreboard bench for fdiv_sched with a 2-cycle behavioural divider.
// Handshakes push expected responses; a monitor pops on rsp_valid_o.
module tb_fdiv_sched;

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic [3:0]   req_valid;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   req_ready;
  logic [31:0]  div_a, div_b, div_res;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_result;
  logic         rsp_nan, rsp_inf, busy;

  fdiv_sched dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .enable_i     (enable),
    .req_valid_i  (req_valid),
    .req_a_i      (req_a),
    .req_b_i      (req_b),
    .req_ready_o  (req_ready),
    .div_a_o      (div_a),
    .div_b_o      (div_b),
    .div_result_i (div_res),
    .rsp_valid_o  (rsp_valid),
    .rsp_id_o     (rsp_id),
    .rsp_result_o (rsp_result),
    .rsp_nan_o    (rsp_nan),
    .rsp_inf_o    (rsp_inf),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] q;
    logic        nan;
    logic        inf;
    int          c;
  } exp_t;

  exp_t        exp_q[$];
  int          hs_ids[$];
  int          hs_cyc[$];
  int          cmp_n = 0;
  int          err_n = 0;
  int          cyc = 0;
  logic [3:0]  gnt_seen = '0;
  logic        hs_last = 1'b0;
  logic [63:0] ops_ref = '0;
  logic [63:0] p1 = '0;

  // Hand-computed quotients: {nan, inf, quotient}.
  function automatic logic [33:0] model(input logic [63:0] ab);
    case (ab)
      {32'h41000000, 32'h40000000}: return {2'b00, 32'h40800000};
      {32'h41100000, 32'h40400000}: return {2'b00, 32'h40400000};
      {32'h40C00000, 32'h40000000}: return {2'b00, 32'h40400000};
      {32'h41200000, 32'h40800000}: return {2'b00, 32'h40200000};
      {32'h00000000, 32'h00000000}: return {2'b10, 32'h7FC00000};
      {32'hBF800000, 32'h00000000}: return {2'b01, 32'hFF800000};
      default:                      return {2'b00, 32'hDEADBEEF};
    endcase
  endfunction

  logic [33:0] m_tmp;

  // Divider: operands sampled in two consecutive cycles.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    p1      <= {div_a, div_b};
    m_tmp    = model(p1);
    div_res <= m_tmp[31:0];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Stimulus-side watcher: handshakes push expectations.
  always @(negedge clk) begin
    logic [33:0] m;
    if (hs_last) ops_ref = {div_a, div_b};
    else if (busy) chk("op_stable", {31'b0, ({div_a, div_b} == ops_ref)}, 1);
    chk("ready_onehot0", {31'b0, $onehot0(req_ready)}, 1);
    gnt_seen = req_valid & req_ready;
    hs_last  = |gnt_seen;
    for (int i = 0; i < 4; i++) begin
      if (gnt_seen[i]) begin
        m = model({req_a[i*32 +: 32], req_b[i*32 +: 32]});
        exp_q.push_back('{id: i, q: m[31:0], nan: m[33], inf: m[32], c: cyc});
        hs_ids.push_back(i);
        hs_cyc.push_back(cyc);
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'(rsp_id), 32'hFFFFFFFF);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(e.id));
        chk("rsp_result", rsp_result, e.q);
        chk("rsp_nan", 32'(rsp_nan), 32'(e.nan));
        chk("rsp_inf", 32'(rsp_inf), 32'(e.inf));
        chk("rsp_latency", 32'(cyc - e.c), 32'd4);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~gnt_seen;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 60; k++) begin
      if (!busy && exp_q.size() == 0 && req_valid == '0) break;
      tick();
    end
    chk("idle_timeout", 32'(k < 60), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b1;
    req_valid = 4'hF;
    req_a = {32'h41200000, 32'h40C00000, 32'h41100000, 32'h41000000};
    req_b = {32'h40800000, 32'h40000000, 32'h40400000, 32'h40000000};

    // Reset with every requester valid.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_div_a", div_a, 32'h0);
    chk("rst_div_b", div_b, 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("rst_rsp_result", rsp_result, 32'h0);
    chk("rst_flags", {30'b0, rsp_nan, rsp_inf}, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    wait_idle();

    // Single op from requester 2: 6.0 / 2.0.
    req_valid[2] = 1'b1;
    @(negedge clk);
    chk("single_ready", 32'(req_ready), 32'h4);
    tick();
    wait_idle();

    // Round-robin with all four valid from a cleared pointer.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    hs_ids.delete();
    hs_cyc.delete();
    req_valid = 4'hF;
    for (int k = 0; k < 30 && hs_ids.size() < 4; k++) tick();
    chk("rr_count", 32'(hs_ids.size()), 32'd4);
    if (hs_ids.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("rr_order", 32'(hs_ids[i]), 32'(i));
        chk("rr_cycle", 32'(hs_cyc[i] - hs_cyc[0]), 32'(3 * i));
      end
    end
    req_valid[1] = 1'b1;
    for (int k = 0; k < 30 && hs_ids.size() < 5; k++) tick();
    chk("rr_late_count", 32'(hs_ids.size()), 32'd5);
    if (hs_ids.size() >= 5) begin
      chk("rr_late_id", 32'(hs_ids[4]), 32'd1);
      chk("rr_late_cycle", 32'(hs_cyc[4] - hs_cyc[0]), 32'd12);
    end
    wait_idle();

    // Specials: 0/0 -> qNaN, -1/0 -> -Inf.
    req_a[1*32 +: 32] = 32'h00000000;
    req_b[1*32 +: 32] = 32'h00000000;
    req_a[3*32 +: 32] = 32'hBF800000;
    req_b[3*32 +: 32] = 32'h00000000;
    req_valid = 4'b1010;
    wait_idle();

    // Enable dropped during WAIT with a request pending.
    req_valid[0] = 1'b1;
    tick();
    enable = 1'b0;
    req_valid[2] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("en_low_ready", 32'(req_ready), 32'h0);
      tick();
    end
    enable = 1'b1;
    @(negedge clk);
    chk("en_resume_ready", 32'(req_ready), 32'h4);
    tick();
    wait_idle();

    // Reset in the middle of WAIT.
    req_valid = 4'b0010;
    tick();
    tick();
    rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_ready", 32'(req_ready), 32'h0);
    chk("mid_rst_rsp", 32'(rsp_valid), 32'h0);
    tick();
    rst_n = 1'b1;
    req_valid = 4'b1010;
    @(negedge clk);
    chk("post_rst_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    wait_idle();
    repeat (3) tick();
    chk("sb_drain", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
